div_radix2: RTL



---
 rtl/div_radix2_pkg.sv | 29 ++
 rtl/div_step.sv | 24 ++
 rtl/div_radix2.sv | 133 +++++++++++++
 3 files changed

// File: rtl/div_radix2_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM state encodings,
// handshake level names, the zero word and an operand magnitude helper.
// Optional feature macro used by the top: DIV_EARLY_EXIT_EN.
package div_radix2_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } divState_t;

  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

  // Number of shift/subtract iterations for a 32-bit quotient
  localparam logic [5:0]  IterCount         = 6'd32;

  // Absolute value in signed mode, pass-through in unsigned mode.
  // -2^31 maps onto 0x80000000, which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] value,
                                            input logic        isSigned);
    return (isSigned && value[31]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shifts the 64-bit {rem, quo} partial left
// by one, trial-subtracts the divisor from the upper 33 bits and either keeps
// the difference (quotient bit 1) or restores (quotient bit 0).
// Purely combinational so two copies can be chained for a radix-4 variant.
module div_step (
  input  logic [63:0] i_partial,
  input  logic [31:0] i_divisor,
  output logic [63:0] o_partial
);

  logic [32:0] w_upper;
  logic        w_ge;
  logic [31:0] w_rem;

  // After the shift the upper 33 bits are {rem, quo[31]}; the remainder
  // before the shift is below the divisor, so the difference fits in 32 bits.
  assign w_upper = i_partial[63:31];
  assign w_ge    = (w_upper >= {1'b0, i_divisor});
  assign w_rem   = w_ge ? (w_upper[31:0] - i_divisor) : w_upper[31:0];

  // Bit 0 of the new partial is the freshly produced quotient bit
  assign o_partial = {w_rem, i_partial[30:0], w_ge};

endmodule

// File: rtl/div_radix2.sv
// Iterative 32-bit radix-2 restoring divider answering the EX-stage DIV/DIVU
// handshake. Returns {remainder, quotient} with ready_o held until EX drops
// start_i. Define DIV_EARLY_EXIT_EN to finish at once when |dividend| is
// smaller than |divisor|; results are identical either way.
module div_radix2
  import div_radix2_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  divState_t   r_state;
  logic        r_signMode;
  logic        r_dvdNeg;
  logic        r_dvsNeg;
  logic [31:0] r_divisor;
  logic [63:0] r_partial;
  logic [5:0]  r_count;

  logic [31:0] w_dvdMag;
  logic [31:0] w_dvsMag;
  logic [63:0] w_stepPartial;
  logic [31:0] w_quoFix;
  logic [31:0] w_remFix;
  logic        w_earlyExit;
  logic        w_abort;

  assign w_dvdMag = magnitude(opdata1_i, signed_div_i);
  assign w_dvsMag = magnitude(opdata2_i, signed_div_i);

`ifdef DIV_EARLY_EXIT_EN
  assign w_earlyExit = (w_dvdMag < w_dvsMag);
`else
  assign w_earlyExit = 1'b0;
`endif

  // A running operation is dropped when EX annuls it or withdraws the request
  assign w_abort = annul_i || (start_i == DivStop);

  div_step u_step (
    .i_partial (r_partial),
    .i_divisor (r_divisor),
    .o_partial (w_stepPartial)
  );

  // Quotient is negative when operand signs differ; remainder follows dividend
  assign w_quoFix = (r_signMode && (r_dvdNeg ^ r_dvsNeg)) ? (~r_partial[31:0] + 32'd1)
                                                          : r_partial[31:0];
  assign w_remFix = (r_signMode && r_dvdNeg) ? (~r_partial[63:32] + 32'd1)
                                             : r_partial[63:32];

  // Divider FSM: operand capture, iteration, sign fix and result handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= DivFree;
      r_signMode <= 1'b0;
      r_dvdNeg   <= 1'b0;
      r_dvsNeg   <= 1'b0;
      r_divisor  <= ZeroWord;
      r_partial  <= {ZeroWord, ZeroWord};
      r_count    <= 6'd0;
      result_o   <= {ZeroWord, ZeroWord};
      ready_o    <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          if ((start_i == DivStart) && !annul_i) begin
            r_signMode <= signed_div_i;
            r_dvdNeg   <= signed_div_i & opdata1_i[31];
            r_dvsNeg   <= signed_div_i & opdata2_i[31];
            r_divisor  <= w_dvsMag;
            r_count    <= 6'd0;
            if (opdata2_i == ZeroWord) begin
              r_partial <= {ZeroWord, ZeroWord};
              r_state   <= DivByZero;
            end else if (w_earlyExit) begin
              // Remainder is the whole dividend; skip straight to the sign fix
              r_partial <= {w_dvdMag, ZeroWord};
              r_count   <= IterCount;
              r_state   <= DivOn;
            end else begin
              r_partial <= {ZeroWord, w_dvdMag};
              r_state   <= DivOn;
            end
          end
        end

        DivByZero: begin
          if (w_abort) begin
            r_state <= DivFree;
          end else if (r_count != 6'd0) begin
            result_o <= {ZeroWord, ZeroWord};
            ready_o  <= DivResultReady;
            r_state  <= DivEnd;
          end else begin
            r_count <= r_count + 6'd1;
          end
        end

        DivOn: begin
          if (w_abort) begin
            r_state <= DivFree;
          end else if (r_count == IterCount) begin
            result_o <= {w_remFix, w_quoFix};
            ready_o  <= DivResultReady;
            r_state  <= DivEnd;
          end else begin
            r_partial <= w_stepPartial;
            r_count   <= r_count + 6'd1;
          end
        end

        DivEnd: begin
          if (start_i == DivStop) begin
            result_o <= {ZeroWord, ZeroWord};
            ready_o  <= DivResultNotReady;
            r_state  <= DivFree;
          end
        end

        default: r_state <= DivFree;
      endcase
    end
  end

endmodule
